// File: rtl/psm_pkg.sv
// psm_pkg: scheduler state encoding and psm phase timing shared by the scheduler files.
package psm_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} t_sched_state;
  localparam int TIME_OP1 = 3;
  localparam int TIME_OP2 = 1;
  localparam int TIME_OP3 = 8;
  localparam int PSM_JOB_CYC = TIME_OP1 + TIME_OP2 + TIME_OP3 + 1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting just after LastId.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [ID_W-1:0]    LastId,
  output logic [NUM_REQ-1:0] Win,
  output logic [ID_W-1:0]    WinId,
  output logic               Any
);
  int idx;
  logic [ID_W-1:0] sel;
  // Walk from lowest to highest priority so the nearest requester after LastId overwrites the rest.
  always_comb begin
    Win = '0;
    WinId = '0;
    idx = 0;
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(LastId) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (Req[sel]) begin
        Win = '0;
        Win[sel] = 1'b1;
        WinId = sel;
      end
    end
  end
  assign Any = |Req;
endmodule

// File: rtl/psm_sched.sv
// psm_sched: round-robin scheduler that launches a shared psm unit and returns its three phase results.
module psm_sched
  import psm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [NUM_REQ*8-1:0] ReqDin1,
  input  logic [NUM_REQ*8-1:0] ReqDin2,
  output logic [NUM_REQ-1:0]   Gnt,
  output logic                 Busy,
  output logic                 Done,
  output logic [ID_W-1:0]      DoneId,
  output logic                 DoneErr,
  output logic [7:0]           ResOr,
  output logic [7:0]           ResXor,
  output logic [7:0]           ResOp3,
  output logic                 PsmStart,
  output logic [7:0]           PsmDin1,
  output logic [7:0]           PsmDin2,
  input  logic                 PsmReady,
  input  logic                 PsmOp1,
  input  logic                 PsmOp2,
  input  logic                 PsmOp3,
  input  logic [7:0]           PsmDout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  t_sched_state state, state_nx;
  logic [ID_W-1:0] last_id, win_id;
  logic [NUM_REQ-1:0] win;
  logic any, grant, seen_op3, fin_ok, tmo, finish;
  logic [CNT_W-1:0] cnt;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .Req(Req),
    .LastId(last_id),
    .Win(win),
    .WinId(win_id),
    .Any(any)
  );

  assign grant = state == IDLE && any && PsmReady;
  assign fin_ok = PsmReady && seen_op3;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign finish = state == BUSY && (fin_ok || tmo);
  assign Busy = state != IDLE;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? LAUNCH : IDLE;
      LAUNCH:  state_nx = BUSY;
      BUSY:    state_nx = finish ? DONE : BUSY;
      default: state_nx = IDLE;
    endcase
  end

  // Grant and Start are registered from IDLE only, so Start can never repeat on adjacent cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_id <= ID_W'(NUM_REQ - 1);
      Gnt <= '0;
      PsmStart <= 1'b0;
      PsmDin1 <= '0;
      PsmDin2 <= '0;
      cnt <= '0;
      seen_op3 <= 1'b0;
      ResOr <= '0;
      ResXor <= '0;
      ResOp3 <= '0;
      Done <= 1'b0;
      DoneErr <= 1'b0;
      DoneId <= '0;
    end else begin
      Gnt <= grant ? win : '0;
      PsmStart <= grant;
      if (grant) begin
        PsmDin1 <= ReqDin1[win_id*8 +: 8];
        PsmDin2 <= ReqDin2[win_id*8 +: 8];
        last_id <= win_id;
      end
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      seen_op3 <= state == BUSY && (seen_op3 || PsmOp3);
      if (state == BUSY && PsmOp1) ResOr <= PsmDout;
      if (state == BUSY && PsmOp2) ResXor <= PsmDout;
      if (state == BUSY && PsmOp3) ResOp3 <= PsmDout;
      Done <= finish;
      DoneErr <= finish && !fin_ok;
      if (finish) DoneId <= last_id;
    end
  end
endmodule

// File: tb/tb_psm_sched.sv
// tb_psm_sched: directed checks of psm_sched against a cycle-accurate psm stub.
module tb_psm_sched;
  localparam int N = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, psm_rst, hang;
  logic [N-1:0] req, gnt, gnt_acc;
  logic [8*N-1:0] din1, din2;
  logic busy, done, done_err, psm_start, psm_ready, psm_op1, psm_op2, psm_op3;
  logic [1:0] done_id;
  logic [7:0] res_or, res_xor, res_op3, psm_din1, psm_din2, psm_dout, sa, sb;
  int cyc = 0;
  int ph = 0;
  int done_cnt = 0;
  int errors = 0;
  int checks = 0;

  psm_sched #(.NUM_REQ(N), .TIMEOUT_CYC(32)) dut (
    .Clock(clk), .Reset(rst_n), .Req(req), .ReqDin1(din1), .ReqDin2(din2),
    .Gnt(gnt), .Busy(busy), .Done(done), .DoneId(done_id), .DoneErr(done_err),
    .ResOr(res_or), .ResXor(res_xor), .ResOp3(res_op3),
    .PsmStart(psm_start), .PsmDin1(psm_din1), .PsmDin2(psm_din2),
    .PsmReady(psm_ready), .PsmOp1(psm_op1), .PsmOp2(psm_op2), .PsmOp3(psm_op3),
    .PsmDout(psm_dout)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // psm stub: operands captured at the end of the Start cycle, then 3/1/8 phase cycles and Ready
  always @(posedge clk) begin
    if (psm_rst) ph <= 0;
    else if (psm_start) begin
      sa <= psm_din1;
      sb <= psm_din2;
      ph <= 1;
    end else if (ph == 13) ph <= 0;
    else if (ph > 0) ph <= ph + 1;
  end
  assign psm_op1 = !hang && ph >= 1 && ph <= 3;
  assign psm_op2 = !hang && ph == 4;
  assign psm_op3 = !hang && ph >= 5 && ph <= 12;
  assign psm_ready = !hang && (ph == 0 || ph == 13);
  assign psm_dout = psm_op1 ? (sa | sb) : psm_op2 ? (sa ^ sb) : psm_op3 ? ~(~sa & sb) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(output int id, output int at);
    id = -1;
    at = -1;
    for (int i = 0; i < 60 && id < 0; i++) begin
      @(negedge clk);
      gnt_acc = gnt_acc | gnt;
      for (int k = 0; k < N; k++) if (gnt[k]) id = k;
      if (id >= 0) at = cyc;
    end
    chk("gnt_seen", 32'(id >= 0), 1);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 60 && at < 0; i++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
    chk("done_seen", 32'(at >= 0), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    psm_rst = 1'b1;
    hang = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    psm_rst = 1'b0;
  endtask

  int id, l, d, g, n, dc;
  int exp_f[5] = '{0, 1, 2, 3, 0};
  int exp_a[4] = '{0, 2, 0, 2};

  initial begin
    gnt_acc = '0;
    din1 = '0;
    din2 = '0;
    rst_n = 1'b0;
    psm_rst = 1'b1;
    hang = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", psm_start, 0);
    chk("rst_res_or", res_or, 0);
    chk("rst_done_id", done_id, 0);
    rst_n = 1'b1;
    psm_rst = 1'b0;

    din1[15:8] = 8'h3C;
    din2[15:8] = 8'hA5;
    req = 4'b0010;
    wait_gnt(id, l);
    chk("single_id", id, 1);
    chk("single_gnt", gnt, 4'b0010);
    chk("single_start", psm_start, 1);
    chk("single_din1", psm_din1, 8'h3C);
    chk("single_busy", busy, 1);
    req = '0;
    wait_done(d);
    chk("single_lat", d - l, 14);
    chk("single_done_id", done_id, 1);
    chk("single_or", res_or, 8'hBD);
    chk("single_xor", res_xor, 8'h99);
    chk("single_op3", res_op3, 8'h7E);
    chk("single_err", done_err, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_id_hold", done_id, 1);

    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      n = l;
      wait_gnt(id, l);
      chk("fair_id", id, exp_f[i]);
      if (i > 0) chk("fair_period", l - n, 16);
    end

    do_reset();
    gnt_acc = '0;
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(id, l);
      chk("alt_id", id, exp_a[i]);
    end
    chk("alt_mask", gnt_acc, 4'b0101);

    do_reset();
    din1[7:0] = 8'h11;
    din2[7:0] = 8'h22;
    req = 4'b0001;
    wait_gnt(id, l);
    chk("tmo_id", id, 0);
    hang = 1'b1;
    req = '0;
    wait_done(d);
    chk("tmo_lat", d - l, 33);
    chk("tmo_err", done_err, 1);
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nr_gnt", gnt, 0);
      chk("nr_start", psm_start, 0);
    end
    hang = 1'b0;
    n = cyc;
    wait_gnt(id, g);
    chk("nr_lat", g - n, 1);
    chk("nr_id", id, 0);
    req = '0;
    wait_done(d);
    chk("post_tmo_lat", d - g, 14);
    chk("post_tmo_err", done_err, 0);
    chk("post_tmo_or", res_or, 8'h33);

    do_reset();
    din1[23:16] = 8'h0F;
    din2[23:16] = 8'hF0;
    req = 4'b0100;
    wait_gnt(id, l);
    chk("mid_id", id, 2);
    req = '0;
    repeat (4) @(negedge clk);
    chk("mid_op2", psm_op2, 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_start", psm_start, 0);
    chk("mid_res_or", res_or, 0);
    chk("mid_din1", psm_din1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0001;
    wait_gnt(id, g);
    chk("mid_regrant_lat", g - l, 14);
    chk("mid_regrant_id", id, 0);
    chk("mid_no_done", done_cnt - dc, 0);
    req = '0;
    wait_done(d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psm_sched.md
# psm_sched

Round-robin scheduler that shares one `psm` operation unit between `NUM_REQ` requesters. It accepts operand pairs from requesters and launches the unit with a single-cycle `Start` pulse. It captures the unit's `Dout` during each of the three operation phases (OR, XOR, `~(~A&B)`) and returns the three results to the granted requester with a completion pulse. It sits between the requester fabric and the `psm` instance, and it is the only driver of the unit's `Start`, `Din1` and `Din2` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters; ≥2.
- `TIMEOUT_CYC`, default 32: maximum BUSY cycles before the job is aborted; ≥14.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `Clock` in 1: single clock; all logic is rising-edge.
- `Reset` in 1: asynchronous, active-low reset (0 = reset).
- `Req` in NUM_REQ: per-requester level request; held with its data until `Gnt`.
- `ReqDin1` in NUM_REQ*8: operand A; requester i occupies bits [8i+7:8i].
- `ReqDin2` in NUM_REQ*8: operand B; same packing.
- `Gnt` out NUM_REQ: one-hot, one-cycle accept pulse.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle completion pulse.
- `DoneId` out ID_W: requester served; valid with `Done`, held afterwards.
- `DoneErr` out 1: timeout flag; valid with `Done`.
- `ResOr`, `ResXor`, `ResOp3` out 8 each: captured phase results; held until overwritten.
- `PsmStart` out 1: to `psm.Start`.
- `PsmDin1`, `PsmDin2` out 8 each: to `psm.Din1`/`Din2`.
- `PsmReady`, `PsmOp1`, `PsmOp2`, `PsmOp3` in 1 each: from `psm`.
- `PsmDout` in 8: from `psm.Dout`.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- IDLE:
  - If `|Req` and `PsmReady`=1, pick the winner round-robin, starting from `LastId+1` and wrapping modulo NUM_REQ.
  - Register the winner's operands into `PsmDin1`/`PsmDin2`, register `Gnt[winner]`, set `LastId`, go to LAUNCH.
  - If `PsmReady`=0, grant nothing.
- LAUNCH: lasts one cycle.
  - `PsmStart`=1 and `Gnt[winner]`=1.
  - Clear the timeout counter and the phase-seen flags, go to BUSY.
- BUSY: the counter increments each cycle.
  - `PsmOp1` → `ResOr`←`PsmDout`.
  - `PsmOp2` → `ResXor`←`PsmDout`.
  - `PsmOp3` → `ResOp3`←`PsmDout`, and set `SeenOp3`.
  - `PsmReady`=1 && `SeenOp3` → DONE with err=0.
  - Counter reaches `TIMEOUT_CYC` first → DONE with err=1.
- DONE: lasts one cycle.
  - `Done`=1, `DoneId`=`LastId`, `DoneErr`=err. Go to IDLE.
  - On err, the `Res*` values are undefined to the requester.
- `PsmStart` is never high for two consecutive cycles, so the unit's rising-edge detect always sees a fresh edge.
- Requester duty: drop `Req` after `Gnt`. A `Req` still high on return to IDLE is treated as a new job.
- A single requester is re-granted back-to-back if it is the only one requesting.
- Reset values: state IDLE, `LastId`=NUM_REQ-1 (so requester 0 wins first), all outputs 0, counter 0.
- Reset mid-job: everything returns to reset values immediately; no `Done` is issued for the aborted job. The `psm` has its own synchronous active-high reset. If it is not also reset, IDLE waits for `PsmReady`=1 before granting.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Grant at cycle L. `psm` captures its operands at the end of L.
  - Op1 phase: L+1..L+3.
  - Op2 phase: L+4.
  - Op3 phase: L+5..L+12.
  - `PsmReady` seen in cycle L+13.
  - `Done` in cycle L+14.
- Back-to-back: IDLE at L+15, next `Gnt` at L+16, so a 16-cycle job period.
- Timeout: BUSY spans L+1..L+TIMEOUT_CYC. With `Done`=1 and `DoneErr`=1 at L+TIMEOUT_CYC+1, this is L+33 at the default.

## Structure
- `psm_pkg` holds:
  - `t_sched_state` enum (IDLE/LAUNCH/BUSY/DONE, 2 bits).
  - `TIME_OP1`=3, `TIME_OP2`=1, `TIME_OP3`=8.
  - `PSM_JOB_CYC`=TIME_OP1+TIME_OP2+TIME_OP3+1=13, the minimum BUSY length. `TIMEOUT_CYC` must exceed it.
- One sub-module, `rr_pick`: purely combinational round-robin selector. Inputs are `Req` and `LastId`; outputs are one-hot `Win`, `WinId` and `Any`.
- The `psm` instance is external.

## Test plan
- Single job: requester 1 sends A=0x3C, B=0xA5 → `Gnt[1]` at L; `Done` at L+14 with `DoneId`=1, `ResOr`=0xBD, `ResXor`=0x99, `ResOp3`=0x7E, `DoneErr`=0.
- Fairness: all four `Req` high from reset and re-raised after each grant → grant order 0,1,2,3,0, grants 16 cycles apart.
- Alternation: only req0 and req2 continuously high → grant order 0,2,0,2; req1 and req3 never granted.
- Timeout: stub holds `PsmReady`=0 and all `Op*`=0 after launch → `Done`=1, `DoneErr`=1 at L+33; returns to IDLE and grants again once `PsmReady`=1.
- Not ready: `PsmReady`=0 in IDLE with `Req`=4'b0001 → no `Gnt` and `PsmStart`=0 until `PsmReady` rises; `Gnt[0]` one cycle later.
- Reset mid-Op2 (L+4): all outputs 0 asynchronously, no `Done`; after release with the `psm` still busy, no `Gnt` until `PsmReady`=1.
